usb_frame_parser: RTL
=====================

USB_FRAME_PARSER -- requirements
Module: usb_frame_parser

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 The block SHALL have parameter MAX_PAYLOAD, default 256, giving the largest accepted payload length in bytes.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 60000, giving the inter-byte timeout in clk cycles.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 usb_data_in  input  8  received USB byte.
REQ-007 usb_data_valid_in  input  1  one-cycle strobe; usb_data_in is accepted when this is high.
REQ-008 cmd_type  output  8  command byte of the current frame.
REQ-009 cmd_length  output  16  payload length of the current frame.
REQ-010 cmd_data  output  8  payload byte.
REQ-011 cmd_data_valid  output  1  one-cycle strobe qualifying cmd_data.
REQ-012 cmd_data_index  output  16  zero-based index of cmd_data within the payload.
REQ-013 cmd_start  output  1  one-cycle pulse; header accepted.
REQ-014 cmd_done  output  1  one-cycle pulse; frame complete and checksum correct.
REQ-015 parse_error  output  1  one-cycle pulse; frame aborted.

Function
REQ-016 The frame format SHALL be: 0xAA, 0x55, CMD, LEN_H, LEN_L, LEN payload bytes, CHK.
REQ-017 CHK SHALL equal the 8-bit modulo-256 sum of CMD, LEN_H, LEN_L and all payload bytes.
REQ-018 The state machine SHALL have the states IDLE, SYNC2, CMD, LEN_H, LEN_L, PAYLOAD and CHECKSUM, and SHALL advance only on cycles where usb_data_valid_in is high.
REQ-019 In IDLE, byte 0xAA SHALL move to SYNC2; any other byte SHALL leave the machine in IDLE.
REQ-020 In SYNC2: 0x55 SHALL move to CMD; 0xAA SHALL stay in SYNC2; any other byte SHALL return to IDLE with no error.
REQ-021 In CMD, the byte SHALL be latched as the command and the machine SHALL move to LEN_H; in LEN_H, the byte SHALL be latched as the length high byte and the machine SHALL move to LEN_L.
REQ-022 In LEN_L, the byte SHALL be latched as the length low byte; a 16-bit length greater than MAX_PAYLOAD SHALL pulse parse_error one cycle later, return to IDLE, and produce no cmd_start.
REQ-023 When the length in LEN_L is within range, cmd_type and cmd_length SHALL update and cmd_start SHALL pulse one cycle after the LEN_L byte; the state SHALL go to PAYLOAD, or directly to CHECKSUM if the length is 0.
REQ-024 cmd_type and cmd_length SHALL hold their values until the next cmd_start or reset.
REQ-025 In PAYLOAD, each accepted byte SHALL appear on cmd_data with cmd_data_valid high exactly one cycle after acceptance, with cmd_data_index running 0..LEN-1.
REQ-026 After the byte with index LEN-1, the state SHALL move to CHECKSUM.
REQ-027 A 16-bit payload counter SHALL compare against LEN with no wrap-around, because LEN never exceeds MAX_PAYLOAD.
REQ-028 The running sum SHALL be cleared on entry to CMD and SHALL accumulate modulo 256 over CMD, LEN_H, LEN_L and the payload bytes.
REQ-029 In CHECKSUM, the received byte SHALL be compared with the running sum one cycle after acceptance: on a match cmd_done SHALL pulse, on a mismatch parse_error SHALL pulse, and the state SHALL return to IDLE in both cases.
REQ-030 cmd_done and parse_error SHALL never be high in the same cycle.
REQ-031 Downstream SHALL treat payload bytes as tentative until cmd_done, and SHALL discard them on parse_error.
REQ-032 The inter-byte timeout counter SHALL clear on every accepted byte and in IDLE, and SHALL count in all other states.
REQ-033 When the timeout counter reaches TIMEOUT_CYCLES, parse_error SHALL pulse and the state SHALL return to IDLE.
REQ-034 A byte accepted in the same cycle the timeout expires SHALL be accepted, and the timeout SHALL not fire in that cycle.
REQ-035 Back-to-back valid bytes, one per cycle, SHALL be accepted with no loss.
REQ-036 After cmd_done or parse_error, the next byte SHALL be parsed in IDLE; a 0xAA arriving in the cycle after CHK SHALL begin a new frame.

Reset
REQ-037 While rst_n is low, the state SHALL be IDLE and every counter and the running sum SHALL be 0.
REQ-038 While rst_n is low, cmd_type, cmd_length, cmd_data and cmd_data_index SHALL be 0, and cmd_data_valid, cmd_start, cmd_done and parse_error SHALL be 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame silently, with no pulse on parse_error or cmd_done.

Verification
REQ-040 Send AA 55 11 00 03 01 01 DE F4 -> cmd_start with cmd_type=0x11 and cmd_length=3; cmd_data 01,01,DE at indices 0..2; cmd_done once; no parse_error.
REQ-041 Send AA 55 11 00 02 00 02 15 -> cmd_length=2; data 00,02; cmd_done.
REQ-042 Send the REQ-040 frame with CHK=F5 -> all three data strobes appear, then parse_error, no cmd_done, and a following valid frame is parsed correctly.
REQ-043 Send AA 55 11 01 01 (length 257, MAX_PAYLOAD=256) -> parse_error one cycle later, no cmd_start; the next byte is parsed in IDLE.
REQ-044 Send AA 55 11 00 03 01, then idle for TIMEOUT_CYCLES -> parse_error after exactly TIMEOUT_CYCLES idle cycles; also send AA AA 55 20 00 00 20 -> cmd_start with cmd_type=0x20 and cmd_length=0, then cmd_done, with no cmd_data_valid.
REQ-045 Assert rst_n low mid-payload -> all outputs 0 with no pulses; after release, a full valid frame produces cmd_done.

Source files
------------

// File: rtl/usb_frame_parser.sv
// USB command frame parser: AA 55 CMD LEN_H LEN_L payload CHK, with
// per-byte payload strobes, length limit check and inter-byte timeout.
module usb_frame_parser #(
    parameter int MAX_PAYLOAD    = 256,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic [7:0]  cmd_data,
    output logic        cmd_data_valid,
    output logic [15:0] cmd_data_index,
    output logic        cmd_start,
    output logic        cmd_done,
    output logic        parse_error
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SYNC2    = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_LEN_H    = 3'd3;
    localparam logic [2:0] ST_LEN_L    = 3'd4;
    localparam logic [2:0] ST_PAYLOAD  = 3'd5;
    localparam logic [2:0] ST_CHECKSUM = 3'd6;

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]    MAX_LEN  = 17'(MAX_PAYLOAD);

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [7:0]    sum_q, sum_d;
    logic [15:0]   pay_cnt_q, pay_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_type_q, cmd_type_d;
    logic [15:0]   cmd_length_q, cmd_length_d;
    logic [7:0]    cmd_data_q, cmd_data_d;
    logic          cmd_data_valid_q, cmd_data_valid_d;
    logic [15:0]   cmd_data_index_q, cmd_data_index_d;
    logic          cmd_start_q, cmd_start_d;
    logic          cmd_done_q, cmd_done_d;
    logic          parse_error_q, parse_error_d;
    logic [15:0]   len_full_s;

    assign len_full_s = {len_hi_q, usb_data_in};

    // Next-state, datapath and pulse generation for one received byte or idle cycle.
    always_comb begin
        state_d          = state_q;
        cmd_d            = cmd_q;
        len_hi_d         = len_hi_q;
        sum_d            = sum_q;
        pay_cnt_d        = pay_cnt_q;
        tmo_d            = tmo_q;
        cmd_type_d       = cmd_type_q;
        cmd_length_d     = cmd_length_q;
        cmd_data_d       = cmd_data_q;
        cmd_data_index_d = cmd_data_index_q;
        cmd_data_valid_d = 1'b0;
        cmd_start_d      = 1'b0;
        cmd_done_d       = 1'b0;
        parse_error_d    = 1'b0;

        if (usb_data_valid_in) begin
            // An accepted byte always wins over a timeout expiring in the same cycle.
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (usb_data_in == 8'hAA) begin
                        state_d = ST_SYNC2;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SYNC2: begin
                    if (usb_data_in == 8'h55) begin
                        state_d = ST_CMD;
                        sum_d   = 8'h00;
                    end else if (usb_data_in == 8'hAA) begin
                        state_d = ST_SYNC2;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    cmd_d   = usb_data_in;
                    sum_d   = sum8(sum_q, usb_data_in);
                    state_d = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_hi_d = usb_data_in;
                    sum_d    = sum8(sum_q, usb_data_in);
                    state_d  = ST_LEN_L;
                end
                ST_LEN_L: begin
                    sum_d = sum8(sum_q, usb_data_in);
                    if ({1'b0, len_full_s} > MAX_LEN) begin
                        parse_error_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        cmd_start_d  = 1'b1;
                        cmd_type_d   = cmd_q;
                        cmd_length_d = len_full_s;
                        pay_cnt_d    = 16'd0;
                        if (len_full_s == 16'd0) begin
                            state_d = ST_CHECKSUM;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    sum_d            = sum8(sum_q, usb_data_in);
                    cmd_data_d       = usb_data_in;
                    cmd_data_valid_d = 1'b1;
                    cmd_data_index_d = pay_cnt_q;
                    pay_cnt_d        = pay_cnt_q + 16'd1;
                    // Length is bounded by MAX_PAYLOAD, so the +1 never wraps.
                    if ((pay_cnt_q + 16'd1) == cmd_length_q) begin
                        state_d = ST_CHECKSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CHECKSUM: begin
                    if (usb_data_in == sum_q) begin
                        cmd_done_d = 1'b1;
                    end else begin
                        parse_error_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d         = '0;
            parse_error_d = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State, counters and registered outputs; reset aborts silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            cmd_q            <= 8'h00;
            len_hi_q         <= 8'h00;
            sum_q            <= 8'h00;
            pay_cnt_q        <= 16'd0;
            tmo_q            <= '0;
            cmd_type_q       <= 8'h00;
            cmd_length_q     <= 16'd0;
            cmd_data_q       <= 8'h00;
            cmd_data_valid_q <= 1'b0;
            cmd_data_index_q <= 16'd0;
            cmd_start_q      <= 1'b0;
            cmd_done_q       <= 1'b0;
            parse_error_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            len_hi_q         <= len_hi_d;
            sum_q            <= sum_d;
            pay_cnt_q        <= pay_cnt_d;
            tmo_q            <= tmo_d;
            cmd_type_q       <= cmd_type_d;
            cmd_length_q     <= cmd_length_d;
            cmd_data_q       <= cmd_data_d;
            cmd_data_valid_q <= cmd_data_valid_d;
            cmd_data_index_q <= cmd_data_index_d;
            cmd_start_q      <= cmd_start_d;
            cmd_done_q       <= cmd_done_d;
            parse_error_q    <= parse_error_d;
        end
    end

    assign cmd_type       = cmd_type_q;
    assign cmd_length     = cmd_length_q;
    assign cmd_data       = cmd_data_q;
    assign cmd_data_valid = cmd_data_valid_q;
    assign cmd_data_index = cmd_data_index_q;
    assign cmd_start      = cmd_start_q;
    assign cmd_done       = cmd_done_q;
    assign parse_error    = parse_error_q;

endmodule
